// File: rtl/opb_master_simulink2ppc.sv
// rtl/opb_master_simulink2ppc.sv - single-beat OPB master bridge for fabric-issued read/write commands.
// One command in flight; arbitration, retry back-off and transfer timeout are handled here.
module opb_master_simulink2ppc #(
  parameter int    C_OPB_AWIDTH = 32,
  parameter int    C_OPB_DWIDTH = 32,
  parameter int    C_TIMEOUT    = 16,
  parameter int    C_MAX_RETRY  = 3,
  parameter string C_FAMILY     = "virtex6"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
  input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
  input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  output logic                        M_request,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  output logic                        M_seqAddr,
  output logic                        M_busLock,
  input  logic                        OPB_MGrant,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_toutSup,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_BACKOFF, S_RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;
  localparam logic [3:0] MAX_RETRY  = 4'(C_MAX_RETRY);
  localparam logic [7:0] TOUT_LAST  = 8'(C_TIMEOUT - 1);

  state_t                      state_q, state_d;
  logic                        rnw_q, rnw_d;
  logic [0:C_OPB_AWIDTH-1]     addr_q, addr_d;
  logic [0:C_OPB_DWIDTH/8-1]   be_q, be_d;
  logic [0:C_OPB_DWIDTH-1]     wdata_q, wdata_d;
  logic [3:0]                  retry_q, retry_d;
  logic [7:0]                  tout_q, tout_d;
  logic [0:C_OPB_DWIDTH-1]     rdata_q, rdata_d;
  logic [1:0]                  status_q, status_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        m_request_q, m_request_d;
  logic                        m_select_q, m_select_d;
  logic                        m_rnw_q, m_rnw_d;
  logic [0:C_OPB_AWIDTH-1]     m_abus_q, m_abus_d;
  logic [0:C_OPB_DWIDTH/8-1]   m_be_q, m_be_d;
  logic [0:C_OPB_DWIDTH-1]     m_dbus_q, m_dbus_d;

  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    retry_d  = retry_q;
    tout_d   = tout_q;
    rdata_d  = rdata_q;
    status_d = status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rnw_d   = cmd_rnw;
          addr_d  = cmd_addr;
          be_d    = cmd_be;
          wdata_d = cmd_wdata;
          retry_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (OPB_MGrant) begin
          tout_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Error beats ack beats retry beats timeout when several arrive together.
        if (OPB_errAck) begin
          status_d = ST_ERR;
          rdata_d  = '0;
          state_d  = S_RESP;
        end else if (OPB_xferAck) begin
          status_d = ST_OK;
          rdata_d  = rnw_q ? OPB_DBus : '0;
          state_d  = S_RESP;
        end else if (OPB_retry) begin
          if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 4'd1;
            state_d = S_BACKOFF;
          end else begin
            status_d = ST_RETRY;
            rdata_d  = '0;
            state_d  = S_RESP;
          end
        end else if (OPB_toutSup) begin
          tout_d = '0;
        end else if (tout_q == TOUT_LAST) begin
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = S_RESP;
        end else begin
          tout_d = tout_q + 8'd1;
        end
      end
      S_BACKOFF: state_d = S_REQ;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs follow the next state so they are registered and the OR-bus stays clean.
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    m_request_d = (state_d == S_REQ);
    m_select_d  = (state_d == S_XFER);
    m_rnw_d     = m_select_d & rnw_d;
    m_abus_d    = m_select_d ? addr_d : '0;
    m_be_d      = m_select_d ? be_d : '0;
    m_dbus_d    = (m_select_d && !rnw_d) ? wdata_d : '0;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q     <= S_IDLE;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      retry_q     <= '0;
      tout_q      <= '0;
      rdata_q     <= '0;
      status_q    <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      m_request_q <= 1'b0;
      m_select_q  <= 1'b0;
      m_rnw_q     <= 1'b0;
      m_abus_q    <= '0;
      m_be_q      <= '0;
      m_dbus_q    <= '0;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      retry_q     <= retry_d;
      tout_q      <= tout_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      m_request_q <= m_request_d;
      m_select_q  <= m_select_d;
      m_rnw_q     <= m_rnw_d;
      m_abus_q    <= m_abus_d;
      m_be_q      <= m_be_d;
      m_dbus_q    <= m_dbus_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;
  assign M_request  = m_request_q;
  assign M_select   = m_select_q;
  assign M_RNW      = m_rnw_q;
  assign M_ABus     = m_abus_q;
  assign M_BE       = m_be_q;
  assign M_DBus     = m_dbus_q;
  assign M_seqAddr  = 1'b0;
  assign M_busLock  = 1'b0;

endmodule

// File: tb/tb_opb_master_simulink2ppc.sv
// tb/tb_opb_master_simulink2ppc.sv - scoreboard bench: scripted OPB slave/arbiter, response monitor.
module tb_opb_master_simulink2ppc;
  localparam int TMO  = 16;
  localparam int MAXR = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_ERRACK = 2, K_NONE = 3, K_SUP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [0:31] cmd_addr = '0, cmd_wdata = '0;
  logic [0:3]  cmd_be = '0;
  logic        rsp_valid, rsp_ready;
  logic [0:31] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant = 1'b0, OPB_xferAck = 1'b0, OPB_errAck = 1'b0;
  logic        OPB_retry = 1'b0, OPB_toutSup = 1'b0;
  logic [0:31] OPB_DBus = '0;

  always #5 clk = ~clk;

  opb_master_simulink2ppc #(.C_TIMEOUT(TMO), .C_MAX_RETRY(MAXR)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW), .M_ABus(M_ABus),
    .M_BE(M_BE), .M_DBus(M_DBus), .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
    .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup), .OPB_DBus(OPB_DBus)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int first_rsp_cyc = 0;
  int req_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
    int          stall;
    bit          chk_rdata;
  } exp_t;
  exp_t sb[$];

  // Reference outcome from the transaction's scripted slave behaviour.
  function automatic exp_t model(input bit rnw, input int nretry, input int kind,
                                 input logic [31:0] rd, input int stall);
    exp_t e;
    e.stall = stall;
    e.rdata = 32'd0;
    e.chk_rdata = 1'b1;
    if (nretry > MAXR) begin
      e.status = 2'b11;
      e.chk_rdata = 1'b0;
    end else if (kind == K_ERR || kind == K_ERRACK) begin
      e.status = 2'b01;
    end else if (kind == K_NONE) begin
      e.status = 2'b10;
      e.chk_rdata = 1'b0;
    end else begin
      e.status = 2'b00;
      e.rdata = rnw ? rd : 32'd0;
    end
    return e;
  endfunction

  // Response monitor: pops the scoreboard on each response handshake.
  initial begin
    int stall_left;
    bit holding;
    logic [31:0] hd;
    logic [1:0] hs;
    exp_t e;
    rsp_ready = 1'b0;
    holding = 1'b0;
    stall_left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_ready = 1'b0;
        holding = 1'b0;
      end else if (rsp_valid) begin
        chk("cmd_ready_low_in_resp", {31'd0, cmd_ready}, 32'd0);
        if (!holding) begin
          holding = 1'b1;
          hd = rsp_rdata;
          hs = rsp_status;
          first_rsp_cyc = cyc;
          stall_left = (sb.size() > 0) ? sb[0].stall : 0;
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, hd);
          chk("rsp_status_stable", {30'd0, rsp_status}, {30'd0, hs});
        end
        if (stall_left > 0) begin
          rsp_ready = 1'b0;
          stall_left--;
        end else begin
          rsp_ready = 1'b1;
          holding = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_status", {30'd0, rsp_status}, {30'd0, e.status});
            if (e.chk_rdata) chk("rsp_rdata", rsp_rdata, e.rdata);
          end
        end
      end else begin
        rsp_ready = 1'b0;
        holding = 1'b0;
      end
    end
  end

  // OR-bus and tie-off rules, plus a count of bus requests raised.
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!M_select)
        chk("or_bus_idle", M_ABus | M_DBus | {28'd0, M_BE} | {31'd0, M_RNW}, 32'd0);
      chk("ties_and_excl", {30'd0, M_seqAddr | M_busLock, M_request & M_select}, 32'd0);
      if (M_request && !req_prev) req_total++;
      req_prev = M_request;
    end
  end

  task automatic wait_cmd_ready(output bit ok);
    int n;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (!ok) chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_txn(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int gdelay, input int nretry,
                         input int kind, input int adelay, input logic [31:0] rd,
                         input int stall, output int hs_cyc);
    bit ok;
    int a, n, req0;
    bit done;
    hs_cyc = 0;
    wait_cmd_ready(ok);
    if (!ok) return;
    sb.push_back(model(rnw, nretry, kind, rd, stall));
    req0 = req_total;
    cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    hs_cyc = cyc;
    a = 0;
    done = 1'b0;
    while (!done) begin
      n = 0;
      while (!M_request && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!M_request) begin
        chk("request_timeout", {31'd0, M_request}, 32'd1);
        return;
      end
      repeat (gdelay) @(negedge clk);
      chk("request_held", {31'd0, M_request}, 32'd1);
      OPB_MGrant = 1'b1;
      @(negedge clk);
      OPB_MGrant = 1'b0;
      chk("select_after_grant", {31'd0, M_select}, 32'd1);
      chk("xfer_abus", M_ABus, addr);
      chk("xfer_be", {28'd0, M_BE}, {28'd0, be});
      chk("xfer_rnw", {31'd0, M_RNW}, {31'd0, rnw});
      chk("xfer_dbus", M_DBus, rnw ? 32'd0 : wdata);
      if (a < nretry) begin
        repeat (adelay) @(negedge clk);
        OPB_retry = 1'b1;
        @(negedge clk);
        OPB_retry = 1'b0;
        a++;
        chk("post_retry_idle_bus", {30'd0, M_select, M_request}, 32'd0);
        if (a > MAXR) begin
          done = 1'b1;
        end else begin
          @(negedge clk);
          chk("req_after_backoff", {31'd0, M_request}, 32'd1);
        end
      end else begin
        if (kind == K_NONE) begin
          n = 0;
          while (M_select && n < 100) begin
            n++;
            @(negedge clk);
          end
          chk("timeout_xfer_cycles", n, TMO);
        end else begin
          if (kind == K_SUP) begin
            OPB_toutSup = 1'b1;
            repeat (40) @(negedge clk);
            chk("sup_still_selected", {31'd0, M_select}, 32'd1);
            OPB_toutSup = 1'b0;
          end else begin
            repeat (adelay) @(negedge clk);
          end
          OPB_DBus = rd;
          OPB_xferAck = (kind != K_ERR);
          OPB_errAck = (kind == K_ERR || kind == K_ERRACK);
          @(negedge clk);
          OPB_xferAck = 1'b0;
          OPB_errAck = 1'b0;
          OPB_DBus = '0;
          chk("bus_idle_after_ack", {30'd0, M_select, M_request}, 32'd0);
        end
        done = 1'b1;
      end
    end
    wait_cmd_ready(ok);
    chk("request_count", req_total - req0, ((nretry < MAXR) ? nretry : MAXR) + 1);
  endtask

  initial begin
    int hs;
    int kind, nretry;
    bit ok;
    #12;
    chk("reset_outputs", {26'd0, cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_seqAddr} |
        M_ABus | M_DBus | {28'd0, M_BE} | rsp_rdata | {30'd0, rsp_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    run_txn(1'b0, 32'h01100800, 4'hF, 32'hDEADBEEF, 2, 0, K_ACK, 2, 32'h12345678, 0, hs);
    run_txn(1'b1, 32'h01100800, 4'hF, 32'h0, 0, 0, K_ACK, 0, 32'h00000001, 0, hs);
    chk("min_latency_cycles", first_rsp_cyc - hs + 1, 3);
    run_txn(1'b1, 32'h01100804, 4'hF, 32'h0, 1, 3, K_ACK, 1, 32'hCAFEF00D, 0, hs);
    run_txn(1'b1, 32'h01100808, 4'h3, 32'h0, 0, 4, K_ACK, 0, 32'h0, 0, hs);
    run_txn(1'b0, 32'h0110080C, 4'hC, 32'h55AA55AA, 0, 0, K_NONE, 0, 32'h0, 0, hs);
    run_txn(1'b1, 32'h01100810, 4'hF, 32'h0, 0, 0, K_SUP, 0, 32'hA5A5A5A5, 0, hs);
    run_txn(1'b1, 32'h01100814, 4'hF, 32'h0, 0, 0, K_ERRACK, 1, 32'hFFFFFFFF, 0, hs);
    run_txn(1'b1, 32'h01100818, 4'hF, 32'h0, 0, 0, K_ACK, 15, 32'h13579BDF, 10, hs);

    // Reset in the middle of a transfer abandons it without a response.
    wait_cmd_ready(ok);
    cmd_rnw = 1'b1; cmd_addr = 32'h01100900; cmd_be = 4'hF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    OPB_MGrant = 1'b1;
    @(negedge clk);
    OPB_MGrant = 1'b0;
    chk("pre_reset_select", {31'd0, M_select}, 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_kills_xfer", {29'd0, M_select, rsp_valid, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_midreset", {31'd0, cmd_ready}, 32'd1);
    run_txn(1'b0, 32'h01100904, 4'hF, 32'h0BADF00D, 1, 0, K_ACK, 1, 32'h0, 0, hs);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      nretry = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
      run_txn($urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3), nretry, kind, $urandom_range(0, 12), $urandom,
              $urandom_range(0, 3), hs);
    end
    wait_cmd_ready(ok);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
